// File: rtl/coo_edge_loader.sv
// Streams a fixed-length batch of graph edges into COO column memory.
// Optional COO_LOAD_RANGE_CHECK_EN drops and flags out-of-range edges.
module coo_edge_loader #(
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_ADDRESS_WIDTH = $clog2(COO_NUM_OF_COLS),
  parameter int NUM_OF_NODES      = 6,
  parameter int NODE_WIDTH        = $clog2(NUM_OF_NODES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         edge_valid,
  output logic                         edge_ready,
  input  logic [NODE_WIDTH-1:0]        edge_src,
  input  logic [NODE_WIDTH-1:0]        edge_dst,
  output logic                         coo_wr_en,
  output logic [COO_ADDRESS_WIDTH-1:0] coo_wr_address,
  output logic [2*NODE_WIDTH-1:0]      coo_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic [COO_ADDRESS_WIDTH:0]   edge_count,
  output logic                         range_error
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam logic [COO_ADDRESS_WIDTH-1:0] LAST_IDX =
    COO_ADDRESS_WIDTH'(COO_NUM_OF_COLS - 1);

  state_t state;
  state_t state_next;

  logic [COO_ADDRESS_WIDTH-1:0] wr_idx;
  logic                         accept;
  logic                         in_range;
  logic                         write;
  logic                         last;
  logic                         begin_load;

  assign accept     = edge_valid && edge_ready;
  assign write      = accept && in_range;
  assign last       = wr_idx == LAST_IDX;
  assign begin_load = (state == IDLE) && start;

`ifdef COO_LOAD_RANGE_CHECK_EN
  localparam logic [NODE_WIDTH:0] NODE_LIM =
    (NODE_WIDTH + 1)'(NUM_OF_NODES);

  assign in_range = ({1'b0, edge_src} < NODE_LIM)
                 && ({1'b0, edge_dst} < NODE_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      range_error <= 1'b0;
    end else if (begin_load) begin
      range_error <= 1'b0;
    end else if (accept && !in_range) begin
      range_error <= 1'b1;
    end
  end
`else
  assign in_range    = 1'b1;
  assign range_error = 1'b0;
`endif

  // ready is a pure state decode so upstream never sees a valid->ready path
  always_comb begin
    state_next = state;
    edge_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        edge_ready = 1'b1;
        busy       = 1'b1;
        if (write && last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wr_idx         <= '0;
      edge_count     <= '0;
      coo_wr_en      <= 1'b0;
      coo_wr_address <= '0;
      coo_wr_data    <= '0;
    end else begin
      state     <= state_next;
      coo_wr_en <= write;
      if (begin_load) begin
        wr_idx     <= '0;
        edge_count <= '0;
      end else if (write) begin
        coo_wr_address <= wr_idx;
        coo_wr_data    <= {edge_src, edge_dst};
        wr_idx         <= last ? '0 : wr_idx + 1'b1;
        edge_count     <= edge_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coo_edge_loader.sv
// Directed bench for coo_edge_loader: writes, handshake gaps,
// start/reset priority and range handling.
module tb_coo_edge_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       edge_valid;
  logic       edge_ready;
  logic [2:0] edge_src;
  logic [2:0] edge_dst;
  logic       coo_wr_en;
  logic [2:0] coo_wr_address;
  logic [5:0] coo_wr_data;
  logic       busy;
  logic       done;
  logic [3:0] edge_count;
  logic       range_error;

  coo_edge_loader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .edge_valid     (edge_valid),
    .edge_ready     (edge_ready),
    .edge_src       (edge_src),
    .edge_dst       (edge_dst),
    .coo_wr_en      (coo_wr_en),
    .coo_wr_address (coo_wr_address),
    .coo_wr_data    (coo_wr_data),
    .busy           (busy),
    .done           (done),
    .edge_count     (edge_count),
    .range_error    (range_error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [2:0] vs [0:6];
  logic [2:0] vd [0:6];
  logic [5:0] exp_data [0:5];

  logic [2:0] wq_addr [$];
  logic [5:0] wq_data [$];
  int         done_cnt;
  logic [2:0] done_addr;
  logic       done_wen;

  always @(negedge clk) begin
    if (coo_wr_en) begin
      wq_addr.push_back(coo_wr_address);
      wq_data.push_back(coo_wr_data);
    end
    if (done) begin
      done_cnt  = done_cnt + 1;
      done_addr = coo_wr_address;
      done_wen  = coo_wr_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    done_cnt  = 0;
    done_addr = '0;
    done_wen  = 1'b0;
  endtask

  task automatic set_edge(input int i, input logic [2:0] s,
                          input logic [2:0] d);
    vs[i] = s;
    vd[i] = d;
  endtask

  task automatic load_ring();
    for (int i = 0; i < 6; i++) begin
      set_edge(i, 3'(i), 3'((i + 1) % 6));
      exp_data[i] = {3'(i), 3'((i + 1) % 6)};
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic stream(input int first, input int last, input int gap);
    logic acc;
    int   cnt;
    for (int i = first; i <= last; i++) begin
      edge_valid = 1'b1;
      edge_src   = vs[i];
      edge_dst   = vd[i];
      cnt = 0;
      forever begin
        @(negedge clk);
        acc = edge_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        cnt++;
        if (cnt > 20) begin
          chk("ready_timeout", 32'(edge_ready), 32'd1);
          break;
        end
      end
      if (gap != 0) begin
        edge_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    edge_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n,
                              input int n_done);
    chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wq_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wq_data[i]),
          32'(exp_data[i]));
    end
    chk({tag, "_ndone"}, 32'(done_cnt), 32'(n_done));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    edge_valid = 1'b0;
    edge_src   = '0;
    edge_dst   = '0;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(edge_ready), 32'd0);
    chk("rst_wen", 32'(coo_wr_en), 32'd0);
    chk("rst_addr", 32'(coo_wr_address), 32'd0);
    chk("rst_data", 32'(coo_wr_data), 32'd0);
    chk("rst_cnt", 32'(edge_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rerr", 32'(range_error), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    load_ring();
    clear_log();
    pulse_start();
    stream(0, 5, 0);
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_done_wen", 32'(coo_wr_en), 32'd1);
    chk("b2b_done_addr", 32'(coo_wr_address), 32'd5);
    chk("b2b_done_busy", 32'(busy), 32'd1);
    chk("b2b_done_cnt", 32'(edge_count), 32'd6);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_done", 32'(done), 32'd0);
    chk("b2b_idle_wen", 32'(coo_wr_en), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_writes("b2b", 6, 1);
    chk("b2b_cnt_hold", 32'(edge_count), 32'd6);

    clear_log();
    pulse_start();
    stream(0, 5, 1);
    repeat (3) @(posedge clk);
    #1;
    check_writes("gap", 6, 1);
    chk("gap_done_addr", 32'(done_addr), 32'd5);
    chk("gap_done_wen", 32'(done_wen), 32'd1);

    clear_log();
    start      = 1'b1;
    edge_valid = 1'b1;
    edge_src   = vs[0];
    edge_dst   = vd[0];
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sv_no_early_wen", 32'(coo_wr_en), 32'd0);
    chk("sv_cnt_clr", 32'(edge_count), 32'd0);
    chk("sv_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    stream(1, 5, 0);
    repeat (3) @(posedge clk);
    #1;
    check_writes("sv", 6, 1);

    clear_log();
    pulse_start();
    stream(0, 2, 0);
    reset      = 1'b1;
    start      = 1'b1;
    edge_valid = 1'b1;
    edge_src   = vs[3];
    edge_dst   = vd[3];
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rl_wen", 32'(coo_wr_en), 32'd0);
    chk("rl_busy", 32'(busy), 32'd0);
    chk("rl_cnt", 32'(edge_count), 32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    start      = 1'b0;
    edge_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_writes("rl", 3, 0);
    clear_log();
    pulse_start();
    stream(0, 5, 0);
    repeat (3) @(posedge clk);
    #1;
    check_writes("rl_re", 6, 1);

    set_edge(0, 3'd0, 3'd1);
    set_edge(1, 3'd1, 3'd2);
    set_edge(2, 3'd6, 3'd2);
    set_edge(3, 3'd2, 3'd3);
    set_edge(4, 3'd3, 3'd4);
    set_edge(5, 3'd4, 3'd5);
    set_edge(6, 3'd5, 3'd0);
    clear_log();
    pulse_start();
`ifdef COO_LOAD_RANGE_CHECK_EN
    exp_data[0] = 6'o01;
    exp_data[1] = 6'o12;
    exp_data[2] = 6'o23;
    exp_data[3] = 6'o34;
    exp_data[4] = 6'o45;
    exp_data[5] = 6'o50;
    stream(0, 6, 0);
    repeat (3) @(posedge clk);
    #1;
    check_writes("rc", 6, 1);
    chk("rc_rerr", 32'(range_error), 32'd1);
`else
    exp_data[0] = 6'o01;
    exp_data[1] = 6'o12;
    exp_data[2] = 6'o62;
    exp_data[3] = 6'o23;
    exp_data[4] = 6'o34;
    exp_data[5] = 6'o45;
    stream(0, 5, 0);
    repeat (3) @(posedge clk);
    #1;
    check_writes("rc", 6, 1);
    chk("rc_rerr", 32'(range_error), 32'd0);
`endif
    chk("rc_cnt", 32'(edge_count), 32'd6);
    pulse_start();
    @(negedge clk);
    chk("rc_rerr_clr", 32'(range_error), 32'd0);
    chk("rc_cnt_clr", 32'(edge_count), 32'd0);
    chk("rc_busy", 32'(busy), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/coo_edge_loader.md
COO_EDGE_LOADER -- requirements
Module: coo_edge_loader

Interface
REQ-001 SHALL have parameter COO_NUM_OF_COLS, default 6: number of COO edges (columns) per load.
REQ-002 SHALL have parameter COO_ADDRESS_WIDTH, default $clog2(COO_NUM_OF_COLS): COO memory address width.
REQ-003 SHALL have parameter NUM_OF_NODES, default 6: number of valid graph node indices.
REQ-004 SHALL have parameter NODE_WIDTH, default $clog2(NUM_OF_NODES): width of one node index.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request a new load; honoured only in IDLE.
REQ-008 edge_valid  input  1  upstream edge present.
REQ-009 edge_ready  output  1  loader accepts an edge this cycle.
REQ-010 edge_src  input  NODE_WIDTH  source node index of the offered edge.
REQ-011 edge_dst  input  NODE_WIDTH  destination node index of the offered edge.
REQ-012 coo_wr_en  output  1  COO memory write strobe.
REQ-013 coo_wr_address  output  COO_ADDRESS_WIDTH  COO column index being written.
REQ-014 coo_wr_data  output  2*NODE_WIDTH  {src, dst}, src in upper half.
REQ-015 busy  output  1  high in LOAD and DONE.
REQ-016 done  output  1  one-cycle pulse when the load completes.
REQ-017 edge_count  output  COO_ADDRESS_WIDTH+1  edges written in the current/last load.
REQ-018 range_error  output  1  sticky out-of-range edge flag.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DONE.
REQ-020 IDLE: edge_ready=0; start=1 -> LOAD next cycle, write index and edge_count cleared to 0, range_error cleared.
REQ-021 LOAD: edge_ready=1 (decoded from state only, no combinational path from edge_valid).
REQ-022 An edge SHALL be accepted iff edge_valid && edge_ready at a rising edge.
REQ-023 An accepted edge SHALL be written with 1-cycle latency: next cycle coo_wr_en=1, coo_wr_address=current write index, coo_wr_data={edge_src,edge_dst} as sampled.
REQ-024 coo_wr_en SHALL be 0 in every cycle not following an accepted, written edge; coo_wr_address/data hold last value otherwise.
REQ-025 After each written edge the write index SHALL increment by 1 and edge_count by 1.
REQ-026 Accepting the edge written at index COO_NUM_OF_COLS-1 SHALL move FSM to DONE; index wraps to 0; edge_ready=0 from that next cycle.
REQ-027 DONE SHALL last exactly one cycle with done=1 (coincident with the last coo_wr_en), then return to IDLE.
REQ-028 start in LOAD or DONE SHALL be ignored; start and edge_valid in the same IDLE cycle SHALL NOT accept the edge.
REQ-029 edge_count SHALL hold its final value (COO_NUM_OF_COLS in the absence of drops) in IDLE until the next honoured start.
REQ-030 edge_valid in IDLE or DONE SHALL be ignored, no write, no state change.

Reset
REQ-031 reset SHALL force, on the next rising edge: state=IDLE, write index=0, edge_count=0, coo_wr_en=0, coo_wr_address=0, coo_wr_data=0, done=0, range_error=0.
REQ-032 reset mid-LOAD SHALL abandon the load; no write or done pulse SHALL follow; reset has priority over start and edge handshakes.

Configuration
REQ-033 Macro COO_LOAD_RANGE_CHECK_EN SHALL select the range-check feature.
REQ-034 With COO_LOAD_RANGE_CHECK_EN defined: an accepted edge with edge_src>=NUM_OF_NODES or edge_dst>=NUM_OF_NODES SHALL be consumed but not written; write index and edge_count unchanged; range_error set and held until next honoured start or reset.
REQ-035 Without COO_LOAD_RANGE_CHECK_EN: every accepted edge SHALL be written; range_error SHALL be constant 0.

Verification
REQ-036 Reset, then start, 6 back-to-back edges (0,1),(1,2),(2,3),(3,4),(4,5),(5,0) -> writes at addresses 0..5 on consecutive cycles with matching data, done pulse with address 5 write, edge_count=6, busy=0 one cycle later.
REQ-037 Same stream with edge_valid toggling every other cycle -> same 6 writes in order, no write on idle cycles, done once.
REQ-038 edge_valid=1 and start=1 together in IDLE, then start again during LOAD -> first edge written only after LOAD entered; second start has no effect; address sequence 0..5 unaffected.
REQ-039 reset asserted after 3 accepted edges -> no further coo_wr_en, no done; subsequent start and 6 edges -> writes restart at address 0.
REQ-040 With COO_LOAD_RANGE_CHECK_EN: edge (6,2) inserted as 3rd edge among 7 -> it is not written, range_error=1 sticky, 6 valid edges written at 0..5, edge_count=6; next start clears range_error to 0.
REQ-041 Without COO_LOAD_RANGE_CHECK_EN: same stimulus -> (6,2) written at address 2, done after 6th accepted edge, range_error stays 0.
